uart_cfg_wr_ctrl: RTL and testbench
===================================

Name: uart_cfg_wr_ctrl

Overview:
Parametrised write controller for the UART configuration path. Armed by start_wr, it counts NUM_BYTES received bytes and issues one shift_rxregs pulse per byte. After the final byte it issues a load_confregs/done_wr pulse. New over the previous generation: configurable frame length, rising-edge byte detection, inter-byte timeout, abort input, error reporting and an exposed byte count.

Parameters:
NUM_BYTES, 11, bytes per configuration frame (≥1)
CNT_W, 4, width of byte_cnt (must hold NUM_BYTES-1)
TIMEOUT_CYCLES, 50000, max clk cycles between bytes once a frame has started; 0 disables timeout
TO_W, 16, width of timeout counter (must hold TIMEOUT_CYCLES-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_wr  in  1  arm request, level or pulse, sampled in IDLE only
rxrdy  in  1  UART byte-ready; one rising edge = one byte
abort  in  1  cancel current frame
shift_rxregs  out  1  one-cycle shift strobe per accepted byte
load_confregs  out  1  one-cycle load strobe at frame end
done_wr  out  1  one-cycle frame-complete pulse, coincident with load_confregs
err_wr  out  1  one-cycle error pulse (timeout or abort)
busy  out  1  high in every state except IDLE
byte_cnt  out  CNT_W  bytes accepted in the current frame
wr_leds  out  3  state code

Behaviour:
- Reset (sync, every rising clk edge with rst=1): state=IDLE, byte_cnt=0, timer=0, rxrdy_d=0. Outputs shift_rxregs, load_confregs, done_wr, err_wr and busy are 0; wr_leds=001. rst overrides all other inputs, including mid-frame; no strobe is emitted on reset.
- Edge detect: rx_edge = rxrdy & ~rxrdy_d. rxrdy_d is a register updated every cycle. A rxrdy level held for many cycles counts as one byte.
- Outputs are a Moore decode of the registered state. byte_cnt is a register.
- IDLE (leds 001): if start_wr=1, go to WAIT. rx_edge is ignored.
- WAIT (leds 010):
  - If abort=1, go to ERR. abort has priority over rx_edge and timeout.
  - Else if rx_edge=1, go to SHIFT.
  - Else if TIMEOUT_CYCLES≠0, byte_cnt≠0 and timer==TIMEOUT_CYCLES-1, go to ERR.
  - Else stay in WAIT.
  - timer increments only in WAIT with byte_cnt≠0. It clears in every other state.
- SHIFT (leds 011): shift_rxregs=1 for exactly one cycle.
  - byte_cnt increments at the end of the cycle.
  - If byte_cnt==NUM_BYTES-1 (the last byte), go to LOAD. Else go to WAIT.
  - abort sampled in SHIFT takes effect in the next WAIT cycle.
- LOAD (leds 100): load_confregs=1 and done_wr=1 for one cycle. byte_cnt clears to 0. Go to IDLE.
- ERR (leds 101): err_wr=1 for one cycle. byte_cnt clears to 0. No load_confregs. Go to IDLE.
- Unused state encodings: leds 111, all strobes 0, next state IDLE.
- Latency:
  - rxrdy rises in cycle t while in WAIT → shift_rxregs high in cycle t+1.
  - Last byte edge at t → load_confregs/done_wr high at t+2.
  - From the LOAD cycle, IDLE is reached at the next cycle and busy falls.
- rx_edge in SHIFT, LOAD or ERR is dropped, not queued. The UART guarantees ≥2 cycles between edges.
- start_wr while busy=1 is ignored. Holding start_wr=1 through LOAD re-arms on the cycle after return to IDLE.
- Timeout is not active before the first byte, so an armed controller may wait indefinitely for byte 1.
- NUM_BYTES=1: WAIT→SHIFT→LOAD on the first byte.

Test Plan:
- Reset, start_wr pulse, 11 rxrdy edges spaced 20 cycles → 11 single-cycle shift_rxregs; byte_cnt 1..10 in the WAIT intervals; one load_confregs+done_wr 2 cycles after edge 11; byte_cnt=0; busy=0; leds 001.
- Armed, rxrdy held high 30 cycles then low, repeated 11× → exactly 11 shift pulses; no extra counts from the held level.
- TIMEOUT_CYCLES=100, 3 bytes then silence → err_wr pulse exactly 100 cycles after the WAIT entry following byte 3; no load_confregs; byte_cnt=0; leds 101 for one cycle then 001.
- abort and rx_edge in the same WAIT cycle after byte 5 → err_wr, no sixth shift pulse, return to IDLE. A subsequent 11-byte frame completes normally.
- rxrdy edges in IDLE without start_wr → no strobes, byte_cnt stays 0. rst asserted after byte 7 → next cycle IDLE, all outputs at reset values, no strobe.
- Rerun with NUM_BYTES=1 and NUM_BYTES=4 → load_confregs after 1 and 4 shift pulses respectively.

Source files
------------

// File: rtl/uart_cfg_wr_ctrl.sv
// rtl/uart_cfg_wr_ctrl.sv - UART configuration-frame write controller
// Counts NUM_BYTES rxrdy edges per armed frame and emits shift/load/error strobes.
module uart_cfg_wr_ctrl #(
  parameter int NUM_BYTES      = 11,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_wr,
  input  logic             rxrdy,
  input  logic             abort,
  output logic             shift_rxregs,
  output logic             load_confregs,
  output logic             done_wr,
  output logic             err_wr,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [2:0]       wr_leds
);

  // State encodings double as the LED codes.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_WAIT  = 3'b010,
    S_SHIFT = 3'b011,
    S_LOAD  = 3'b100,
    S_ERR   = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           r_state;
  state_t           w_next;
  logic             r_rxrdy_d;
  logic             r_abort_pend;
  logic [TO_W-1:0]  r_timer;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             w_rx_edge;
  logic             w_abort;
  logic             w_timeout;

  assign w_rx_edge = rxrdy & ~r_rxrdy_d;
  // An abort seen during SHIFT is held so it still lands in the following WAIT.
  assign w_abort   = abort | r_abort_pend;
  assign w_timeout = TO_EN && (r_byte_cnt != '0) && (r_timer == TO_LAST);

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (start_wr) w_next = S_WAIT;
        else          w_next = S_IDLE;
      end
      S_WAIT: begin
        if (w_abort)        w_next = S_ERR;
        else if (w_rx_edge) w_next = S_SHIFT;
        else if (w_timeout) w_next = S_ERR;
        else                w_next = S_WAIT;
      end
      S_SHIFT: begin
        if (r_byte_cnt == LAST_CNT) w_next = S_LOAD;
        else                        w_next = S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rxrdy_d    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_timer      <= '0;
      r_byte_cnt   <= '0;
    end else begin
      r_state      <= w_next;
      r_rxrdy_d    <= rxrdy;
      r_abort_pend <= (r_state == S_SHIFT) && abort;
      // Inter-byte timer only runs once the frame has its first byte.
      if ((r_state == S_WAIT) && (r_byte_cnt != '0)) r_timer <= r_timer + TO_W'(1);
      else                                           r_timer <= '0;
      case (r_state)
        S_SHIFT:      r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        S_LOAD, S_ERR: r_byte_cnt <= '0;
        default:      r_byte_cnt <= r_byte_cnt;
      endcase
    end
  end

  always_comb begin
    shift_rxregs  = 1'b0;
    load_confregs = 1'b0;
    done_wr       = 1'b0;
    err_wr        = 1'b0;
    busy          = (r_state != S_IDLE);
    wr_leds       = 3'b111;
    case (r_state)
      S_IDLE:  wr_leds = 3'b001;
      S_WAIT:  wr_leds = 3'b010;
      S_SHIFT: begin
        wr_leds      = 3'b011;
        shift_rxregs = 1'b1;
      end
      S_LOAD: begin
        wr_leds       = 3'b100;
        load_confregs = 1'b1;
        done_wr       = 1'b1;
      end
      S_ERR: begin
        wr_leds = 3'b101;
        err_wr  = 1'b1;
      end
      default: wr_leds = 3'b111;
    endcase
  end

  assign byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_uart_cfg_wr_ctrl.sv
// tb/tb_uart_cfg_wr_ctrl.sv - scoreboard bench for uart_cfg_wr_ctrl
// Three instances: 11-byte frame with short timeout, 1-byte and 4-byte frames.
module tb_uart_cfg_wr_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] stb;
    logic [2:0] leds;
    logic [3:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic start0, rx0, abort0;
  logic start1, rx1;
  logic start2, rx2;
  logic shift0, load0, done0, err0, busy0;
  logic shift1, load1, done1, err1, busy1;
  logic shift2, load2, done2, err2, busy2;
  logic [3:0] cnt0;
  logic [0:0] cnt1;
  logic [2:0] cnt2;
  logic [2:0] leds0, leds1, leds2;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  uart_cfg_wr_ctrl #(.NUM_BYTES(11), .CNT_W(4), .TIMEOUT_CYCLES(100), .TO_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .start_wr(start0), .rxrdy(rx0), .abort(abort0),
    .shift_rxregs(shift0), .load_confregs(load0), .done_wr(done0), .err_wr(err0),
    .busy(busy0), .byte_cnt(cnt0), .wr_leds(leds0));

  uart_cfg_wr_ctrl #(.NUM_BYTES(1), .CNT_W(1), .TIMEOUT_CYCLES(0), .TO_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start_wr(start1), .rxrdy(rx1), .abort(1'b0),
    .shift_rxregs(shift1), .load_confregs(load1), .done_wr(done1), .err_wr(err1),
    .busy(busy1), .byte_cnt(cnt1), .wr_leds(leds1));

  uart_cfg_wr_ctrl #(.NUM_BYTES(4), .CNT_W(3), .TIMEOUT_CYCLES(50000), .TO_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .start_wr(start2), .rxrdy(rx2), .abort(1'b0),
    .shift_rxregs(shift2), .load_confregs(load2), .done_wr(done2), .err_wr(err2),
    .busy(busy2), .byte_cnt(cnt2), .wr_leds(leds2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop(input int id);
    case (id)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic mon(input int id, input logic [3:0] stb, input logic [2:0] leds, input logic [3:0] cnt);
    exp_t e;
    if (stb == 4'b0000) return;
    total++;
    if (qsize(id) == 0) begin
      bad++;
      $display("FAIL unexpected_strobe dut%0d cyc=%0d got stb=%b leds=%b cnt=%0d, none expected", id, cyc, stb, leds, cnt);
      return;
    end
    e = pop(id);
    if (e.cyc != cyc || e.stb != stb || e.leds != leds || e.cnt != cnt) begin
      bad++;
      $display("FAIL strobe_event dut%0d got cyc=%0d stb=%b leds=%b cnt=%0d, want cyc=%0d stb=%b leds=%b cnt=%0d",
               id, cyc, stb, leds, cnt, e.cyc, e.stb, e.leds, e.cnt);
    end
  endtask

  // Monitor: strobe order {shift, load, done, err}
  always @(negedge clk) begin
    mon(0, {shift0, load0, done0, err0}, leds0, cnt0);
    mon(1, {shift1, load1, done1, err1}, leds1, {3'b000, cnt1});
    mon(2, {shift2, load2, done2, err2}, leds2, {1'b0, cnt2});
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int id, input logic v);
    case (id)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic arm(input int id);
    case (id)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    tick();
  endtask

  // One byte: rxrdy high for hold cycles, low for low cycles; c returns the edge cycle.
  task automatic send_byte(input int id, input int k, input int n, input int hold, input int low, output int c);
    c = cyc;
    set_rx(id, 1'b1);
    push(id, '{cyc: c + 1, stb: 4'b1000, leds: 3'b011, cnt: 4'(k)});
    if (k == n - 1) push(id, '{cyc: c + 2, stb: 4'b0110, leds: 3'b100, cnt: 4'(n)});
    repeat (hold) tick();
    set_rx(id, 1'b0);
    repeat (low) tick();
  endtask

  initial begin
    int c;
    rst = 1'b1;
    start0 = 1'b0; rx0 = 1'b0; abort0 = 1'b0;
    start1 = 1'b0; rx1 = 1'b0;
    start2 = 1'b0; rx2 = 1'b0;
    repeat (3) tick();
    chk("reset_dut0", {busy0, leds0, cnt0, shift0, load0, done0, err0}, {1'b0, 3'b001, 4'd0, 4'b0000});
    chk("reset_dut1", {busy1, leds1, cnt1}, {1'b0, 3'b001, 1'b0});
    chk("reset_dut2", {busy2, leds2, cnt2}, {1'b0, 3'b001, 3'd0});
    rst = 1'b0;
    tick();

    // Single-cycle rxrdy pulses, 20 cycles apart.
    arm(0);
    chk("armed_wait", {busy0, leds0}, {1'b1, 3'b010});
    for (int k = 0; k < 11; k++) begin
      send_byte(0, k, 11, 1, 19, c);
      chk("t1_byte_cnt", int'(cnt0), (k == 10) ? 0 : k + 1);
    end
    chk("t1_idle", {busy0, leds0, cnt0}, {1'b0, 3'b001, 4'd0});

    // rxrdy held high for 30 cycles per byte.
    arm(0);
    for (int k = 0; k < 11; k++) send_byte(0, k, 11, 30, 10, c);
    chk("t2_idle", {busy0, leds0, cnt0}, {1'b0, 3'b001, 4'd0});

    // Timeout 100 cycles after the WAIT entry following byte 3.
    arm(0);
    for (int k = 0; k < 3; k++) send_byte(0, k, 11, 1, 19, c);
    push(0, '{cyc: c + 102, stb: 4'b0001, leds: 3'b101, cnt: 4'd3});
    while (cyc < c + 101) tick();
    chk("t3_pre_timeout", {busy0, leds0, cnt0}, {1'b1, 3'b010, 4'd3});
    tick();
    chk("t3_err_cycle", {leds0, err0, load0}, {3'b101, 1'b1, 1'b0});
    tick();
    chk("t3_idle", {busy0, leds0, cnt0}, {1'b0, 3'b001, 4'd0});

    // abort and rx edge together after byte 5.
    arm(0);
    for (int k = 0; k < 5; k++) send_byte(0, k, 11, 1, 19, c);
    c = cyc;
    rx0 = 1'b1;
    abort0 = 1'b1;
    push(0, '{cyc: c + 1, stb: 4'b0001, leds: 3'b101, cnt: 4'd5});
    tick();
    rx0 = 1'b0;
    abort0 = 1'b0;
    repeat (5) tick();
    chk("t4_idle", {busy0, leds0, cnt0}, {1'b0, 3'b001, 4'd0});
    arm(0);
    for (int k = 0; k < 11; k++) send_byte(0, k, 11, 1, 9, c);
    chk("t4_recover_idle", {busy0, leds0, cnt0}, {1'b0, 3'b001, 4'd0});

    // Edges in IDLE are ignored.
    for (int k = 0; k < 3; k++) begin
      rx0 = 1'b1;
      tick();
      rx0 = 1'b0;
      repeat (4) tick();
    end
    chk("t5_idle_edges", {busy0, leds0, cnt0}, {1'b0, 3'b001, 4'd0});

    // Reset mid-frame after byte 7.
    arm(0);
    for (int k = 0; k < 7; k++) send_byte(0, k, 11, 1, 9, c);
    chk("t6_pre_rst_cnt", int'(cnt0), 7);
    rst = 1'b1;
    tick();
    chk("t6_rst_state", {busy0, leds0, cnt0, shift0, load0, done0, err0}, {1'b0, 3'b001, 4'd0, 4'b0000});
    rst = 1'b0;
    repeat (3) tick();

    // NUM_BYTES=1, two frames.
    for (int f = 0; f < 2; f++) begin
      arm(1);
      send_byte(1, 0, 1, 1, 9, c);
      chk("n1_idle", {busy1, leds1, cnt1}, {1'b0, 3'b001, 1'b0});
    end

    // NUM_BYTES=4.
    arm(2);
    for (int k = 0; k < 4; k++) begin
      send_byte(2, k, 4, 1, 9, c);
      chk("n4_byte_cnt", int'(cnt2), (k == 3) ? 0 : k + 1);
    end
    chk("n4_idle", {busy2, leds2}, {1'b0, 3'b001});

    repeat (5) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
